// File: rtl/pipeline_ctrl.sv
// Pipeline sequencing controller: stage enables, flushes, PC select,
// virtual write-back register and saturating performance counters.
module pipeline_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Need_Stall,
  input  logic             EX__Branch_Taken,
  input  logic             Mem_Wait,
  input  logic [4:0]       MEMwb__Rdst,
  input  logic             MEMwb__R_WE,
  input  logic             Cnt_Clr,
  output logic             PC_WE,
  output logic             PC_Src,
  output logic             IFid__WE,
  output logic             IFid__Flush,
  output logic             IDex__WE,
  output logic             IDex__Flush,
  output logic             EXmem__WE,
  output logic             MEMwb__WE,
  output logic [4:0]       VWB__Rdst,
  output logic             VWB__R_WE,
  output logic             BubbleMA,
  output logic [CNT_W-1:0] Stall_Cnt,
  output logic [CNT_W-1:0] Flush_Cnt,
  output logic [CNT_W-1:0] Freeze_Cnt,
  output logic             Stall_Err
);

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic             frz, fls, stl;
  logic [4:0]       vwb_rdst_q, vwb_rdst_d;
  logic             vwb_rwe_q, vwb_rwe_d;
  logic             bubble_q, bubble_d;
  logic             hist_q, hist_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v,
    input logic             en
  );
    return (en && (v != '1)) ? v + ONE : v;
  endfunction

  // Mutually exclusive decode of the priority chain
  assign frz = Mem_Wait;
  assign fls = !Mem_Wait && EX__Branch_Taken;
  assign stl = !Mem_Wait && !EX__Branch_Taken && Need_Stall;

  always_comb begin
    PC_WE       = 1'b1;
    PC_Src      = 1'b0;
    IFid__WE    = 1'b1;
    IFid__Flush = 1'b0;
    IDex__WE    = 1'b1;
    IDex__Flush = 1'b0;
    EXmem__WE   = 1'b1;
    MEMwb__WE   = 1'b1;
    if (rst) begin
      IFid__Flush = 1'b1;
      IDex__Flush = 1'b1;
    end else begin
      unique case (1'b1)
        frz: begin
          PC_WE     = 1'b0;
          IFid__WE  = 1'b0;
          IDex__WE  = 1'b0;
          EXmem__WE = 1'b0;
          MEMwb__WE = 1'b0;
        end
        fls: begin
          PC_Src      = 1'b1;
          IFid__Flush = 1'b1;
          IDex__Flush = 1'b1;
        end
        stl: begin
          PC_WE       = 1'b0;
          IFid__WE    = 1'b0;
          IDex__Flush = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    vwb_rdst_d   = vwb_rdst_q;
    vwb_rwe_d    = vwb_rwe_q;
    bubble_d     = bubble_q;
    hist_d       = hist_q;
    err_d        = err_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    freeze_cnt_d = freeze_cnt_q;
    if (!Mem_Wait) begin
      vwb_rdst_d = MEMwb__Rdst;
      vwb_rwe_d  = MEMwb__R_WE;
      bubble_d   = stl;
      hist_d     = stl;
    end
    if (Cnt_Clr) begin
      err_d        = 1'b0;
      stall_cnt_d  = '0;
      flush_cnt_d  = '0;
      freeze_cnt_d = '0;
    end else begin
      err_d        = err_q || (stl && hist_q);
      stall_cnt_d  = sat_inc(stall_cnt_q, stl);
      flush_cnt_d  = sat_inc(flush_cnt_q, fls);
      freeze_cnt_d = sat_inc(freeze_cnt_q, frz);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vwb_rdst_q   <= '0;
      vwb_rwe_q    <= 1'b0;
      bubble_q     <= 1'b0;
      hist_q       <= 1'b0;
      err_q        <= 1'b0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
      freeze_cnt_q <= '0;
    end else begin
      vwb_rdst_q   <= vwb_rdst_d;
      vwb_rwe_q    <= vwb_rwe_d;
      bubble_q     <= bubble_d;
      hist_q       <= hist_d;
      err_q        <= err_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
    end
  end

  assign VWB__Rdst  = vwb_rdst_q;
  assign VWB__R_WE  = vwb_rwe_q;
  assign BubbleMA   = bubble_q;
  assign Stall_Err  = err_q;
  assign Stall_Cnt  = stall_cnt_q;
  assign Flush_Cnt  = flush_cnt_q;
  assign Freeze_Cnt = freeze_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: one task per scenario,
// second instance with CNT_W=2 for counter saturation.
module tb_pipeline_ctrl;

  logic clk = 1'b0;
  logic rst, ns, br, mw, rwe, clr;
  logic [4:0] rdst;

  logic pc_we, pc_src, if_we, if_fl;
  logic id_we, id_fl, ex_we, mw_we;
  logic [4:0] vrd;
  logic vwe, bub, serr;
  logic [15:0] scnt, fcnt, zcnt;

  logic b_pc_we, b_pc_src, b_if_we, b_if_fl;
  logic b_id_we, b_id_fl, b_ex_we, b_mw_we;
  logic [4:0] b_vrd;
  logic b_vwe, b_bub, b_serr;
  logic [1:0] b_scnt, b_fcnt, b_zcnt;

  logic [7:0] ctl;
  assign ctl = {pc_we, pc_src, if_we, if_fl,
                id_we, id_fl, ex_we, mw_we};

  localparam logic [7:0] C_RUN = 8'b1010_1011;
  localparam logic [7:0] C_FLS = 8'b1111_1111;
  localparam logic [7:0] C_STL = 8'b0000_1111;
  localparam logic [7:0] C_FRZ = 8'b0000_0000;
  localparam logic [7:0] C_RST = 8'b1011_1111;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .Need_Stall(ns),
    .EX__Branch_Taken(br), .Mem_Wait(mw),
    .MEMwb__Rdst(rdst), .MEMwb__R_WE(rwe),
    .Cnt_Clr(clr), .PC_WE(pc_we), .PC_Src(pc_src),
    .IFid__WE(if_we), .IFid__Flush(if_fl),
    .IDex__WE(id_we), .IDex__Flush(id_fl),
    .EXmem__WE(ex_we), .MEMwb__WE(mw_we),
    .VWB__Rdst(vrd), .VWB__R_WE(vwe),
    .BubbleMA(bub), .Stall_Cnt(scnt),
    .Flush_Cnt(fcnt), .Freeze_Cnt(zcnt),
    .Stall_Err(serr)
  );

  pipeline_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .Need_Stall(ns),
    .EX__Branch_Taken(br), .Mem_Wait(mw),
    .MEMwb__Rdst(rdst), .MEMwb__R_WE(rwe),
    .Cnt_Clr(clr), .PC_WE(b_pc_we),
    .PC_Src(b_pc_src), .IFid__WE(b_if_we),
    .IFid__Flush(b_if_fl), .IDex__WE(b_id_we),
    .IDex__Flush(b_id_fl), .EXmem__WE(b_ex_we),
    .MEMwb__WE(b_mw_we), .VWB__Rdst(b_vrd),
    .VWB__R_WE(b_vwe), .BubbleMA(b_bub),
    .Stall_Cnt(b_scnt), .Flush_Cnt(b_fcnt),
    .Freeze_Cnt(b_zcnt), .Stall_Err(b_serr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ns = 0; br = 0; mw = 0; clr = 0;
  endtask

  task automatic do_clr();
    idle();
    clr = 1;
    step();
    clr = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle(); rdst = 0; rwe = 0;
    #1;
    n_chk++;
    if (ctl !== C_RST) begin
      n_fail++;
      $display("FAIL rst_ctl got %b exp %b", ctl, C_RST);
    end
    step();
    step();
    rst = 0;
    #1;
    n_chk++;
    if (ctl !== C_RUN) begin
      n_fail++;
      $display("FAIL run_ctl got %b exp %b", ctl, C_RUN);
    end
    n_chk++;
    if ({scnt, fcnt, zcnt} !== 48'd0) begin
      n_fail++;
      $display("FAIL rst_cnt got %h %h %h exp 0",
               scnt, fcnt, zcnt);
    end
    n_chk++;
    if ({vwe, vrd, bub, serr} !== 8'd0) begin
      n_fail++;
      $display("FAIL rst_regs got %b%h%b%b exp 0",
               vwe, vrd, bub, serr);
    end
  endtask

  task automatic test_reset_in_freeze();
    idle(); mw = 1; ns = 1;
    step();
    rst = 1;
    #1;
    n_chk++;
    if (ctl !== C_RST) begin
      n_fail++;
      $display("FAIL rst_frz_ctl got %b exp %b", ctl, C_RST);
    end
    step();
    rst = 0; idle();
    #1;
    n_chk++;
    if ({zcnt, scnt, bub, serr} !== 34'd0) begin
      n_fail++;
      $display("FAIL rst_frz_state got %h %h %b %b exp 0",
               zcnt, scnt, bub, serr);
    end
  endtask

  task automatic test_stall();
    do_clr();
    ns = 1;
    #1;
    n_chk++;
    if (ctl !== C_STL) begin
      n_fail++;
      $display("FAIL stall_ctl got %b exp %b", ctl, C_STL);
    end
    step();
    ns = 0;
    n_chk++;
    if ({bub, scnt, serr} !== {1'b1, 16'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL stall_after got bub=%b cnt=%0d err=%b exp 1 1 0",
               bub, scnt, serr);
    end
    step();
    n_chk++;
    if (bub !== 1'b0) begin
      n_fail++;
      $display("FAIL bubble_clear got %b exp 0", bub);
    end
  endtask

  task automatic test_flush_priority();
    do_clr();
    ns = 1; br = 1;
    #1;
    n_chk++;
    if (ctl !== C_FLS) begin
      n_fail++;
      $display("FAIL flush_ctl got %b exp %b", ctl, C_FLS);
    end
    step();
    idle();
    n_chk++;
    if ({fcnt, scnt, bub} !== {16'd1, 16'd0, 1'b0}) begin
      n_fail++;
      $display("FAIL flush_cnt got f=%0d s=%0d bub=%b exp 1 0 0",
               fcnt, scnt, bub);
    end
  endtask

  task automatic test_freeze();
    do_clr();
    rdst = 5'd7; rwe = 1;
    step();
    rdst = 5'd9; mw = 1;
    #1;
    n_chk++;
    if (ctl !== C_FRZ) begin
      n_fail++;
      $display("FAIL freeze_ctl got %b exp %b", ctl, C_FRZ);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      n_chk++;
      if ({vwe, vrd} !== {1'b1, 5'd7}) begin
        n_fail++;
        $display("FAIL freeze_vwb[%0d] got %b %0d exp 1 7",
                 i, vwe, vrd);
      end
    end
    mw = 0;
    n_chk++;
    if (zcnt !== 16'd3) begin
      n_fail++;
      $display("FAIL freeze_cnt got %0d exp 3", zcnt);
    end
    step();
    n_chk++;
    if (vrd !== 5'd9) begin
      n_fail++;
      $display("FAIL vwb_resume got %0d exp 9", vrd);
    end
    rwe = 0; rdst = 0;
  endtask

  task automatic test_stall_err();
    do_clr();
    ns = 1;
    step();
    mw = 1;
    step();
    n_chk++;
    if ({bub, scnt, zcnt, serr} !== {1'b1, 16'd1, 16'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL err_frz got bub=%b s=%0d z=%0d err=%b exp 1 1 1 0",
               bub, scnt, zcnt, serr);
    end
    mw = 0;
    step();
    ns = 0;
    n_chk++;
    if ({serr, scnt} !== {1'b1, 16'd2}) begin
      n_fail++;
      $display("FAIL err_set got err=%b s=%0d exp 1 2", serr, scnt);
    end
    step();
    n_chk++;
    if ({serr, bub} !== 2'b10) begin
      n_fail++;
      $display("FAIL err_sticky got err=%b bub=%b exp 1 0",
               serr, bub);
    end
    clr = 1; ns = 1;
    step();
    clr = 0; ns = 0;
    n_chk++;
    if ({serr, scnt, zcnt} !== 33'd0) begin
      n_fail++;
      $display("FAIL err_clr got err=%b s=%0d z=%0d exp 0",
               serr, scnt, zcnt);
    end
  endtask

  task automatic test_saturate();
    do_clr();
    ns = 1;
    for (int i = 1; i <= 5; i++) begin
      step();
      n_chk++;
      if (b_scnt !== 2'((i > 3) ? 3 : i)) begin
        n_fail++;
        $display("FAIL sat2[%0d] got %0d exp %0d",
                 i, b_scnt, (i > 3) ? 3 : i);
      end
    end
    ns = 0;
    n_chk++;
    if (scnt !== 16'd5) begin
      n_fail++;
      $display("FAIL sat16 got %0d exp 5", scnt);
    end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_flush_priority();
    test_freeze();
    test_stall_err();
    test_saturate();
    test_reset_in_freeze();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
